wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: three execution units (ALU, MUL, LSU) compete for
// two register-file write ports. Round-robin priority with starvation
// promotion, same-destination suppression and a one-cycle registered write.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid,
    input  logic [14:0]         req_rd,
    input  logic [3*DATA_W-1:0] req_data,
    output logic [2:0]          req_ready,
    input  logic                rf_stall,
    output logic                wr_en0,
    output logic                wr_en1,
    output logic [4:0]          wr_idx0,
    output logic [4:0]          wr_idx1,
    output logic [DATA_W-1:0]   wr_data0,
    output logic [DATA_W-1:0]   wr_data1
);

    localparam int unsigned NREQ  = 3;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned AGE_W = 4;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);

    logic [1:0]        rr_ptr;
    logic [AGE_W-1:0]  age     [NREQ];
    logic [RD_W-1:0]   rd_of   [NREQ];
    logic [DATA_W-1:0] data_of [NREQ];
    logic [NREQ-1:0]   starved;
    logic [1:0]        ord     [NREQ];
    logic [NREQ-1:0]   gnt;
    logic              p0_vld;
    logic              p1_vld;
    logic [1:0]        p0_src;
    logic [1:0]        p1_src;
    logic [1:0]        last_gnt;

    // Reduce a 0..5 value modulo 3.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        if (v >= 3'd3) begin
            return 2'(v - 3'd3);
        end
        return v[1:0];
    endfunction

    // Unpack per-requester fields and flag starved requesters.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            rd_of[i]   = req_rd[RD_W*i +: RD_W];
            data_of[i] = req_data[DATA_W*i +: DATA_W];
            starved[i] = (age[i] >= AGE_LIM);
        end
    end

    // Final priority order: starved requesters first, each group in round-robin order.
    always_comb begin
        logic [1:0] n;
        logic [1:0] idx;
        n   = '0;
        idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            ord[k] = '0;
        end
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = wrap3(3'(rr_ptr) + 3'(k));
                if (starved[idx] == (pass == 0)) begin
                    ord[n] = idx;
                    n      = n + 2'd1;
                end
            end
        end
    end

    // Walk the priority order granting up to two writing requests; rd=0 is free.
    always_comb begin
        logic [1:0] nw;
        logic [1:0] idx;
        logic       blocked;
        gnt      = '0;
        p0_vld   = 1'b0;
        p1_vld   = 1'b0;
        p0_src   = '0;
        p1_src   = '0;
        last_gnt = '0;
        nw       = '0;
        idx      = '0;
        blocked  = 1'b0;
        for (int unsigned s = 0; s < NREQ; s++) begin
            idx     = ord[s];
            blocked = 1'b0;
            for (int unsigned t = 0; t < NREQ; t++) begin
                if (t < s && gnt[ord[t]] && rd_of[ord[t]] == rd_of[idx]) begin
                    blocked = 1'b1;
                end
            end
            if (!rst && !rf_stall && req_valid[idx] && !blocked &&
                (rd_of[idx] == '0 || nw < 2'd2)) begin
                gnt[idx] = 1'b1;
                last_gnt = idx;
                if (rd_of[idx] != '0) begin
                    if (nw == 2'd0) begin
                        p0_vld = 1'b1;
                        p0_src = idx;
                    end else begin
                        p1_vld = 1'b1;
                        p1_src = idx;
                    end
                    nw = nw + 2'd1;
                end
            end
        end
    end

    assign req_ready = gnt;

    // Round-robin pointer and per-requester waiting ages.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                age[i] <= '0;
            end
        end else begin
            if (|gnt) begin
                rr_ptr <= wrap3(3'(last_gnt) + 3'd1);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !gnt[i]) begin
                    age[i] <= (age[i] == AGE_MAX) ? AGE_MAX : age[i] + 1'b1;
                end else begin
                    age[i] <= '0;
                end
            end
        end
    end

    // Registered write ports; index/data hold while the port is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en0   <= 1'b0;
            wr_en1   <= 1'b0;
            wr_idx0  <= '0;
            wr_idx1  <= '0;
            wr_data0 <= '0;
            wr_data1 <= '0;
        end else begin
            wr_en0 <= p0_vld;
            wr_en1 <= p1_vld;
            if (p0_vld) begin
                wr_idx0  <= rd_of[p0_src];
                wr_data0 <= data_of[p0_src];
            end
            if (p1_vld) begin
                wr_idx1  <= rd_of[p1_src];
                wr_data1 <= data_of[p1_src];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios with literal expectations plus
// a queue-based reference model checked every cycle and a per-requester scoreboard.
module tb_wb_port_arbiter;

    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [14:0]   req_rd;
    logic [3*DW-1:0] req_data;
    logic [2:0]    req_ready;
    logic          rf_stall;
    logic          wr_en0, wr_en1;
    logic [4:0]    wr_idx0, wr_idx1;
    logic [DW-1:0] wr_data0, wr_data1;

    int n_chk  = 0;
    int n_pass = 0;

    wb_port_arbiter #(.DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
        .req_data(req_data), .req_ready(req_ready), .rf_stall(rf_stall),
        .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_idx0(wr_idx0), .wr_idx1(wr_idx1),
        .wr_data0(wr_data0), .wr_data1(wr_data1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] mkdata(input int id, input int n);
        return {8'(id), 24'(n)};
    endfunction

    function automatic int f_rd(input int i);
        return int'(req_rd[5*i +: 5]);
    endfunction

    function automatic logic [DW-1:0] f_data(input int i);
        return req_data[DW*i +: DW];
    endfunction

    // Reference model state
    int          m_rr = 0;
    int          m_age [3] = '{0, 0, 0};
    int          w_cnt [3] = '{0, 0, 0};
    logic        m_en0 = 1'b0, m_en1 = 1'b0;
    logic [4:0]  m_idx0 = '0, m_idx1 = '0;
    logic [DW-1:0] m_d0 = '0, m_d1 = '0;
    bit          m_init = 1'b0;
    int          order[$];
    int          gl[$];
    int          wl[$];
    logic [36:0] sbq [3][$];
    logic [2:0]  exp_rdy;

    task automatic sb_check(input logic [4:0] ix, input logic [DW-1:0] d);
        int id;
        id = int'(d[31:24]);
        chk("sb_avail", 64'((id < 3) && (sbq[id].size() > 0)), 64'(1));
        if (id < 3 && sbq[id].size() > 0) begin
            chk("sb_order", {ix, d}, sbq[id][0]);
            void'(sbq[id].pop_front());
        end
    endtask

    // Compare DUT against the model away from the active edge, then advance the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("wr0", {wr_en0, wr_idx0, wr_data0}, {m_en0, m_idx0, m_d0});
            chk("wr1", {wr_en1, wr_idx1, wr_data1}, {m_en1, m_idx1, m_d1});
            if (wr_en0 && wr_en1) chk("dup_idx", 64'(wr_idx0 != wr_idx1), 64'(1));
            if (wr_en0) sb_check(wr_idx0, wr_data0);
            if (wr_en1) sb_check(wr_idx1, wr_data1);
        end
        order.delete(); gl.delete(); wl.delete();
        for (int k = 0; k < 3; k++) if (m_age[(m_rr + k) % 3] >= LIM) order.push_back((m_rr + k) % 3);
        for (int k = 0; k < 3; k++) if (m_age[(m_rr + k) % 3] <  LIM) order.push_back((m_rr + k) % 3);
        exp_rdy = 3'b000;
        if (!rst && !rf_stall) begin
            foreach (order[o]) begin
                int i;
                bit ok;
                i = order[o];
                ok = req_valid[i];
                foreach (gl[g]) if (f_rd(gl[g]) == f_rd(i)) ok = 1'b0;
                if (f_rd(i) != 0 && wl.size() >= 2) ok = 1'b0;
                if (ok) begin
                    gl.push_back(i);
                    exp_rdy[i] = 1'b1;
                    if (f_rd(i) != 0) wl.push_back(i);
                end
            end
        end
        chk("ready", req_ready, exp_rdy);
        if (m_init)
            for (int i = 0; i < 3; i++)
                if (req_valid[i]) chk("wait_bound", 64'(w_cnt[i] <= LIM + 2), 64'(1));
        if (rst) begin
            m_rr = 0; m_en0 = 0; m_en1 = 0; m_idx0 = 0; m_idx1 = 0; m_d0 = 0; m_d1 = 0;
            for (int i = 0; i < 3; i++) begin m_age[i] = 0; w_cnt[i] = 0; end
            m_init = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && !exp_rdy[i]) begin
                    m_age[i] = (m_age[i] >= 15) ? 15 : m_age[i] + 1;
                    if (!rf_stall) w_cnt[i]++;
                end else begin
                    m_age[i] = 0;
                    w_cnt[i] = 0;
                end
            end
            if (gl.size() > 0) m_rr = (gl[gl.size()-1] + 1) % 3;
            m_en0 = (wl.size() >= 1);
            m_en1 = (wl.size() >= 2);
            if (m_en0) begin
                m_idx0 = 5'(f_rd(wl[0])); m_d0 = f_data(wl[0]);
                sbq[wl[0]].push_back({m_idx0, m_d0});
            end
            if (m_en1) begin
                m_idx1 = 5'(f_rd(wl[1])); m_d1 = f_data(wl[1]);
                sbq[wl[1]].push_back({m_idx1, m_d1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input int r0, input int r1, input int r2, input logic st);
        int r [3];
        r = '{r0, r1, r2};
        req_valid = v;
        rf_stall  = st;
        for (int i = 0; i < 3; i++) begin
            req_rd[5*i +: 5]    = 5'(r[i]);
            req_data[DW*i +: DW] = mkdata(i, r[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 3'b000;
        rf_stall = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] pend;
    logic [2:0] acc;
    int         seq [3];

    initial begin
        rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0; rf_stall = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_wr_en", {wr_en0, wr_en1}, 2'b00);
        chk("rst_idx_data", {wr_idx0, wr_idx1, wr_data0, wr_data1}, 74'(0));
        chk("rst_rr", 64'(dut.rr_ptr), 64'(0));
        tick();

        // three valid, distinct rd; then LSU first
        drive(3'b111, 1, 2, 3, 1'b0); #1;
        chk("s1_ready", req_ready, 3'b011);
        tick();
        chk("s1_wr0", {wr_en0, wr_idx0, wr_data0}, {1'b1, 5'd1, mkdata(0, 1)});
        chk("s1_wr1", {wr_en1, wr_idx1, wr_data1}, {1'b1, 5'd2, mkdata(1, 2)});
        chk("s1_rr", 64'(dut.rr_ptr), 64'(2));
        chk("s1_model_rr", 64'(m_rr), 64'(2));
        drive(3'b111, 4, 5, 3, 1'b0); #1;
        chk("s1b_ready", req_ready, 3'b101);
        tick();
        chk("s1b_wr0", {wr_en0, wr_idx0, wr_data0}, {1'b1, 5'd3, mkdata(2, 3)});
        chk("s1b_wr1", {wr_en1, wr_idx1, wr_data1}, {1'b1, 5'd4, mkdata(0, 4)});
        drive(3'b000, 0, 0, 0, 1'b0);
        tick();

        // same rd conflict
        do_reset();
        drive(3'b011, 5, 5, 0, 1'b0); #1;
        chk("s2_ready", req_ready, 3'b001);
        tick();
        chk("s2_wr0", {wr_en0, wr_idx0, wr_data0}, {1'b1, 5'd5, mkdata(0, 5)});
        chk("s2_en1", wr_en1, 1'b0);
        drive(3'b010, 0, 5, 0, 1'b0); #1;
        chk("s2b_ready", req_ready, 3'b010);
        tick();
        chk("s2b_wr0", {wr_en0, wr_idx0, wr_data0}, {1'b1, 5'd5, mkdata(1, 5)});
        chk("s2b_en1", wr_en1, 1'b0);

        // rd=0 accepted without a port
        do_reset();
        drive(3'b011, 0, 7, 0, 1'b0); #1;
        chk("s3_ready", req_ready, 3'b011);
        tick();
        chk("s3_wr0", {wr_en0, wr_idx0}, {1'b1, 5'd7});
        chk("s3_en1", wr_en1, 1'b0);

        // stall with starvation; rr_ptr set to MUL first
        do_reset();
        drive(3'b001, 1, 0, 0, 1'b0); #1;
        chk("s4_pre_ready", req_ready, 3'b001);
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, 1, 2, 3, 1'b1); #1;
            chk("s4_stall_ready", req_ready, 3'b000);
            tick();
            chk("s4_stall_en", {wr_en0, wr_en1}, 2'b00);
        end
        chk("s4_mul_age", 64'(dut.age[1]), 64'(6));
        chk("s4_model_age", 64'(m_age[1]), 64'(6));
        drive(3'b111, 1, 2, 3, 1'b0); #1;
        chk("s4_rel_ready", req_ready, 3'b110);
        tick();
        chk("s4_wr0", {wr_en0, wr_idx0, wr_data0}, {1'b1, 5'd2, mkdata(1, 2)});
        chk("s4_wr1", {wr_en1, wr_idx1, wr_data1}, {1'b1, 5'd3, mkdata(2, 3)});

        // reset right after a 2-grant cycle
        do_reset();
        drive(3'b011, 1, 2, 0, 1'b0); #1;
        chk("s5_ready", req_ready, 3'b011);
        tick();
        chk("s5_en", {wr_en0, wr_en1}, 2'b11);
        rst = 1'b1;
        drive(3'b111, 3, 4, 5, 1'b0); #1;
        chk("s5_rst_ready", req_ready, 3'b000);
        tick();
        chk("s5_rst_wr", {wr_en0, wr_en1, wr_idx0, wr_idx1}, 12'(0));
        chk("s5_rst_data", {wr_data0, wr_data1}, 64'(0));
        chk("s5_rst_rr", 64'(dut.rr_ptr), 64'(0));
        chk("s5_rst_age", {dut.age[0], dut.age[1], dut.age[2]}, 12'(0));
        rst = 1'b0;
        drive(3'b000, 0, 0, 0, 1'b0); #1;
        chk("s5_post_en", {wr_en0, wr_en1}, 2'b00);
        tick();

        // random held requests with random stalls
        pend = 3'b000;
        seq = '{0, 0, 0};
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 6) begin
                    pend[i] = 1'b1;
                    seq[i]++;
                    req_rd[5*i +: 5]     = 5'($urandom_range(0, 7));
                    req_data[DW*i +: DW] = mkdata(i, seq[i]);
                end
            end
            req_valid = pend;
            rf_stall  = ($urandom_range(0, 9) == 0);
            #3;
            acc = req_ready & req_valid;
            tick();
            pend = pend & ~acc;
        end
        drive(3'b000, 0, 0, 0, 1'b0);
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) chk("sb_drained", 64'(sbq[i].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
